battle_front_ctrl: RTL and testbench
====================================

Name: battle_front_ctrl

Overview:
- Battlefield sequencer. Sits directly upstream of every player and enemy unit FSM.
- Generates the periodic game tick. Computes each side's frontmost alive unit position.
- Issues the move strobe, then the damage strobe. Sums each side's attack output and routes it to the opposing frontmost unit.
- Feeds unitFront, moveSCEN, damageSCEN and damageIn to the units, and detects an enemy breach of the player base.

Parameters:
- N_PLAYER, 4, number of player unit slots.
- N_ENEMY, 4, number of enemy unit slots.
- TICK_DIV, 50000000, clk cycles per game tick; must be >= 8 (bench uses 8).
- FIELD_MAX, 400, player base position; enemies advance from 0 upward.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  game running; low freezes the tick counter.
- player_pos  in  9*N_PLAYER  packed positions; slot i is [9i+8:9i].
- player_alive  in  N_PLAYER  slot in Alive state.
- player_dmg  in  8*N_PLAYER  packed damageOut of player units.
- enemy_pos  in  9*N_ENEMY  packed enemy positions.
- enemy_alive  in  N_ENEMY  slot in Alive state.
- enemy_dmg  in  8*N_ENEMY  packed damageOut of enemy units.
- player_front  out  9  min position of alive players (unitFront to enemies).
- enemy_front  out  9  max position of alive enemies (unitFront to players).
- move_scen  out  1  one-cycle move strobe to all units.
- damage_scen  out  1  one-cycle damage strobe to all units.
- player_dmg_in  out  8*N_PLAYER  per-player damageIn.
- enemy_dmg_in  out  8*N_ENEMY  per-enemy damageIn.
- base_hit  out  1  sticky: enemy reached FIELD_MAX.

Behaviour:
- Reset values:
  - player_front = FIELD_MAX, enemy_front = 0.
  - move_scen, damage_scen, base_hit = 0.
  - All dmg_in vectors = 0.
  - Tick counter = 0. FSM state = WAIT.
- Tick counter:
  - Runs 0..TICK_DIV-1, then wraps to 0. Increments only while enable = 1 and the FSM is not HALT.
  - Tick fires when count == TICK_DIV-1 and FSM is in WAIT. Consecutive move_scen pulses are therefore exactly TICK_DIV cycles apart.
- FSM (one-hot): WAIT, SCAN, MOVE, SETTLE, SUM, DAMAGE, HALT.
  - WAIT -> SCAN on tick.
  - SCAN:
    - Register player_front = min player_pos over alive slots; FIELD_MAX if none alive.
    - Register enemy_front = max enemy_pos over alive slots; 0 if none alive.
    - Latch target indices tp (frontmost player) and te (frontmost enemy). Ties go to the lowest index.
    - If any alive enemy has pos >= FIELD_MAX: set base_hit and go to HALT. Otherwise -> MOVE.
  - MOVE: move_scen = 1 for exactly this cycle; fronts are stable. -> SETTLE.
  - SETTLE: one idle cycle so unit damageOut registers update. -> SUM.
  - SUM:
    - Psum = sum of player_dmg over alive players. Esum = sum of enemy_dmg over alive enemies.
    - Each sum is 10-bit internal, saturated to 255.
    - -> DAMAGE.
  - DAMAGE:
    - damage_scen = 1 for exactly this cycle.
    - enemy_dmg_in[te] = Psum and player_dmg_in[tp] = Esum. All other slots are 0.
    - If the target side had no alive unit at SCAN, its sum is dropped and all of its slots are 0.
    - -> WAIT.
- Damage vector rule: all dmg_in outputs are 0 in every state except DAMAGE. Units compare health against damageIn continuously, so this is mandatory.
- Latency: move_scen asserts 2 cycles after the tick cycle; damage_scen asserts 3 cycles after move_scen.
- enable deasserted mid-sequence: the FSM still completes the sequence to WAIT; only the counter freezes.
- HALT: all strobes and dmg_in are 0; fronts hold; base_hit = 1. Exit only by reset.
- Reset mid-sequence: everything returns to reset values on the next evaluation (asynchronous); no strobe completes.
- Alive mask and positions are sampled only in SCAN; damage values are sampled only in SUM.

Test Plan:
- Reset, TICK_DIV=8, enable=1, no alive units -> move_scen pulses every 8 cycles; player_front=400; enemy_front=0; damage_scen follows 3 cycles after each move_scen with all dmg_in=0.
- Players alive at pos 300 and 250, enemy alive at 10 -> player_front=250, enemy_front=10; move_scen 2 cycles after count 7.
- Player pos 120 dmg 0x20 and player pos 120 dmg 0xF0, enemy slot2 at 119 alive -> in DAMAGE only: enemy_dmg_in[2]=0xFF (saturated), all other slots 0; the tie between players at 120 selects tp=0.
- Two enemies at 50 (slot1) and 50 (slot3), each dmg 0x40 -> player_dmg_in[tp]=0x80 during the damage_scen cycle; enemy_front=50; zero in every other cycle.
- Enemy alive at pos 400 -> base_hit=1 at SCAN; no further move_scen or damage_scen; state holds until reset, after which base_hit=0.
- enable low for 20 cycles starting at count 5 -> no strobes during that time; after re-enable, first move_scen comes 4 cycles later (count 5->7, +2).

Source files
------------

// File: rtl/battle_front_ctrl_if.sv
// Unit-facing bus of the battlefield sequencer: per-slot unit status in,
// fronts, strobes and routed damage out.
interface battle_front_ctrl_if #(
  parameter int N_PLAYER = 4,
  parameter int N_ENEMY  = 4
);
  logic                    enable;
  logic [9*N_PLAYER-1:0]   player_pos;
  logic [N_PLAYER-1:0]     player_alive;
  logic [8*N_PLAYER-1:0]   player_dmg;
  logic [9*N_ENEMY-1:0]    enemy_pos;
  logic [N_ENEMY-1:0]      enemy_alive;
  logic [8*N_ENEMY-1:0]    enemy_dmg;
  logic [8:0]              player_front;
  logic [8:0]              enemy_front;
  logic                    move_scen;
  logic                    damage_scen;
  logic [8*N_PLAYER-1:0]   player_dmg_in;
  logic [8*N_ENEMY-1:0]    enemy_dmg_in;
  logic                    base_hit;

  modport master (
    output enable, player_pos, player_alive, player_dmg,
           enemy_pos, enemy_alive, enemy_dmg,
    input  player_front, enemy_front, move_scen, damage_scen,
           player_dmg_in, enemy_dmg_in, base_hit
  );

  modport slave (
    input  enable, player_pos, player_alive, player_dmg,
           enemy_pos, enemy_alive, enemy_dmg,
    output player_front, enemy_front, move_scen, damage_scen,
           player_dmg_in, enemy_dmg_in, base_hit
  );
endinterface

// File: rtl/battle_front_ctrl.sv
// Battlefield sequencer: periodic game tick, front-line scan, move/damage
// strobes and routing of each side's summed attack to the opposing front unit.
module battle_front_ctrl #(
  parameter int N_PLAYER  = 4,
  parameter int N_ENEMY   = 4,
  parameter int TICK_DIV  = 50000000,
  parameter int FIELD_MAX = 400
) (
  input logic                clk,
  input logic                reset,
  battle_front_ctrl_if.slave bus
);
  // state  | meaning
  // WAIT   | idle until the game tick
  // SCAN   | register fronts/targets, check for base breach
  // MOVE   | move_scen pulse
  // SETTLE | let unit damageOut registers update
  // SUM    | register saturated per-side damage sums
  // DAMAGE | damage_scen pulse, dmg_in routed to target slots
  // HALT   | base breached, frozen until reset

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PI_W  = (N_PLAYER > 1) ? $clog2(N_PLAYER) : 1;
  localparam int EI_W  = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TICK_DIV - 1);
  localparam logic [8:0]       FIELD_MAX_V = 9'(FIELD_MAX);

  typedef enum logic [6:0] {
    S_WAIT   = 7'b0000001,
    S_SCAN   = 7'b0000010,
    S_MOVE   = 7'b0000100,
    S_SETTLE = 7'b0001000,
    S_SUM    = 7'b0010000,
    S_DAMAGE = 7'b0100000,
    S_HALT   = 7'b1000000
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      count;
  logic                  tick;

  logic [8:0]            player_front, enemy_front;
  logic [PI_W-1:0]       tp;
  logic [EI_W-1:0]       te;
  logic                  p_any, e_any;
  logic [7:0]            psum, esum;
  logic                  base_hit;

  logic [8:0]            p_min, e_max;
  logic [PI_W-1:0]       p_idx;
  logic [EI_W-1:0]       e_idx;
  logic                  p_found, e_found, e_breach;
  logic [9:0]            p_acc, e_acc;
  logic [7:0]            p_sat, e_sat;
  logic [8*N_PLAYER-1:0] player_dmg_in_c;
  logic [8*N_ENEMY-1:0]  enemy_dmg_in_c;

  // Tick is gated by enable so a counter frozen at its last value cannot re-fire.
  assign tick = bus.enable && (state == S_WAIT) && (count == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (bus.enable && state != S_HALT) begin
      count <= (count == CNT_LAST) ? '0 : count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_WAIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:   if (tick) state_nxt = S_SCAN;
      S_SCAN:   state_nxt = e_breach ? S_HALT : S_MOVE;
      S_MOVE:   state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_SUM;
      S_SUM:    state_nxt = S_DAMAGE;
      S_DAMAGE: state_nxt = S_WAIT;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_WAIT;
    endcase
  end

  // Strict compares keep the lowest index on ties.
  always_comb begin
    p_min    = FIELD_MAX_V;
    p_idx    = '0;
    p_found  = 1'b0;
    e_max    = '0;
    e_idx    = '0;
    e_found  = 1'b0;
    e_breach = 1'b0;
    p_acc    = '0;
    e_acc    = '0;
    for (int i = 0; i < N_PLAYER; i++) begin
      if (bus.player_alive[i]) begin
        if (!p_found || bus.player_pos[9*i +: 9] < p_min) begin
          p_min = bus.player_pos[9*i +: 9];
          p_idx = PI_W'(i);
        end
        p_found = 1'b1;
        p_acc   = p_acc + 10'(bus.player_dmg[8*i +: 8]);
      end
    end
    for (int j = 0; j < N_ENEMY; j++) begin
      if (bus.enemy_alive[j]) begin
        if (!e_found || bus.enemy_pos[9*j +: 9] > e_max) begin
          e_max = bus.enemy_pos[9*j +: 9];
          e_idx = EI_W'(j);
        end
        e_found = 1'b1;
        if (bus.enemy_pos[9*j +: 9] >= FIELD_MAX_V) e_breach = 1'b1;
        e_acc = e_acc + 10'(bus.enemy_dmg[8*j +: 8]);
      end
    end
    p_sat = (p_acc > 10'd255) ? 8'hFF : p_acc[7:0];
    e_sat = (e_acc > 10'd255) ? 8'hFF : e_acc[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      player_front <= FIELD_MAX_V;
      enemy_front  <= '0;
      tp           <= '0;
      te           <= '0;
      p_any        <= 1'b0;
      e_any        <= 1'b0;
      psum         <= '0;
      esum         <= '0;
      base_hit     <= 1'b0;
    end else begin
      if (state == S_SCAN) begin
        player_front <= p_found ? p_min : FIELD_MAX_V;
        enemy_front  <= e_found ? e_max : 9'd0;
        tp           <= p_idx;
        te           <= e_idx;
        p_any        <= p_found;
        e_any        <= e_found;
        if (e_breach) base_hit <= 1'b1;
      end
      if (state == S_SUM) begin
        psum <= p_sat;
        esum <= e_sat;
      end
    end
  end

  // Units compare health against damageIn continuously: zero outside DAMAGE.
  always_comb begin
    player_dmg_in_c = '0;
    enemy_dmg_in_c  = '0;
    if (state == S_DAMAGE) begin
      if (p_any) player_dmg_in_c[8*tp +: 8] = esum;
      if (e_any) enemy_dmg_in_c[8*te +: 8]  = psum;
    end
  end

  assign bus.player_front  = player_front;
  assign bus.enemy_front   = enemy_front;
  assign bus.move_scen     = (state == S_MOVE);
  assign bus.damage_scen   = (state == S_DAMAGE);
  assign bus.player_dmg_in = player_dmg_in_c;
  assign bus.enemy_dmg_in  = enemy_dmg_in_c;
  assign bus.base_hit      = base_hit;
endmodule

// File: tb/tb_battle_front_ctrl.sv
// Scoreboard bench for battle_front_ctrl: an event-level model schedules
// expected fronts, strobes and damage vectors; a monitor compares every cycle.
module tb_battle_front_ctrl;
  localparam int NP = 4;
  localparam int NE = 4;
  localparam int TD = 8;
  localparam int FM = 400;

  typedef struct { int cyc; logic [8:0] pf; logic [8:0] ef; } front_ev_t;
  typedef struct { int cyc; logic [31:0] pv; logic [31:0] ev; } dmg_ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  battle_front_ctrl_if #(.N_PLAYER(NP), .N_ENEMY(NE)) bus ();

  battle_front_ctrl #(.N_PLAYER(NP), .N_ENEMY(NE), .TICK_DIV(TD), .FIELD_MAX(FM)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // unit stimulus
  logic [8:0] ppos[NP], epos[NE];
  logic       palive[NP], ealive[NE];
  logic [7:0] pdmg[NP], edmg[NE];
  logic       en;

  // model state (stimulus process only)
  int   mcount, scan_at, sum_at, busy_until, halt_cyc;
  bit   halted, pany, eany;
  int   tp, te;

  // scoreboard
  front_ev_t front_q[$];
  int        move_q[$];
  dmg_ev_t   dmg_q[$];
  logic [8:0] cur_pf, cur_ef;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    bus.enable = en;
    for (int i = 0; i < NP; i++) begin
      bus.player_pos[9*i +: 9] = ppos[i];
      bus.player_alive[i]      = palive[i];
      bus.player_dmg[8*i +: 8] = pdmg[i];
    end
    for (int i = 0; i < NE; i++) begin
      bus.enemy_pos[9*i +: 9] = epos[i];
      bus.enemy_alive[i]      = ealive[i];
      bus.enemy_dmg[8*i +: 8] = edmg[i];
    end
  endtask

  task automatic model_clear();
    mcount = 0; scan_at = -1; sum_at = -1; busy_until = -1;
    halt_cyc = 32'h7fffffff; halted = 1'b0;
  endtask

  task automatic do_scan();
    front_ev_t f;
    bit breach;
    f.cyc = cyc + 1; f.pf = 9'(FM); f.ef = 9'd0;
    pany = 0; eany = 0; tp = 0; te = 0; breach = 0;
    for (int i = 0; i < NP; i++)
      if (palive[i] && (!pany || ppos[i] < f.pf)) begin f.pf = ppos[i]; tp = i; pany = 1; end
    for (int i = 0; i < NE; i++) begin
      if (ealive[i] && (!eany || epos[i] > f.ef)) begin f.ef = epos[i]; te = i; eany = 1; end
      if (ealive[i] && int'(epos[i]) >= FM) breach = 1;
    end
    front_q.push_back(f);
    if (breach) begin
      halted = 1; halt_cyc = cyc + 1; sum_at = -1;
    end else begin
      move_q.push_back(cyc + 1);
    end
  endtask

  task automatic do_sum();
    dmg_ev_t d;
    int ps, es;
    ps = 0; es = 0;
    for (int i = 0; i < NP; i++) if (palive[i]) ps += int'(pdmg[i]);
    for (int i = 0; i < NE; i++) if (ealive[i]) es += int'(edmg[i]);
    if (ps > 255) ps = 255;
    if (es > 255) es = 255;
    d.cyc = cyc + 1; d.pv = '0; d.ev = '0;
    if (pany) d.pv[8*tp +: 8] = 8'(es);
    if (eany) d.ev[8*te +: 8] = 8'(ps);
    dmg_q.push_back(d);
  endtask

  // advance the model by the cycle whose inputs were just driven
  task automatic step();
    bit tk;
    tk = !halted && en && mcount == TD - 1 && cyc > busy_until;
    if (!halted && en) mcount = (mcount + 1) % TD;
    if (scan_at == cyc) do_scan();
    if (sum_at == cyc) do_sum();
    if (tk) begin scan_at = cyc + 1; sum_at = cyc + 4; busy_until = cyc + 5; end
  endtask

  task automatic one_cycle();
    @(negedge clk);
    drive();
    step();
  endtask

  task automatic reset_dut(input int n);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    repeat (n) @(negedge clk);
    reset = 1'b0;
    drive();
    step();
  endtask

  task automatic kill_all();
    for (int i = 0; i < NP; i++) begin palive[i] = 0; ppos[i] = 9'd0; pdmg[i] = 8'd0; end
    for (int i = 0; i < NE; i++) begin ealive[i] = 0; epos[i] = 9'd0; edmg[i] = 8'd0; end
  endtask

  task automatic randomize_units();
    for (int i = 0; i < NP; i++) begin
      palive[i] = ($urandom_range(0, 3) != 0);
      ppos[i]   = 9'($urandom_range(0, FM - 1));
      pdmg[i]   = 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < NE; i++) begin
      ealive[i] = ($urandom_range(0, 3) != 0);
      epos[i]   = 9'($urandom_range(0, FM - 1));
      edmg[i]   = 8'($urandom_range(0, 255));
    end
  endtask

  // monitor: compares the DUT against the scoreboard every cycle
  initial begin
    cur_pf = 9'(FM); cur_ef = 9'd0;
    forever begin
      @(posedge clk); #2;
      if (reset) begin
        chk("rst_player_front", bus.player_front, FM);
        chk("rst_enemy_front", bus.enemy_front, 0);
        chk("rst_strobes", {bus.move_scen, bus.damage_scen, bus.base_hit}, 0);
        chk("rst_dmg_in", {bus.player_dmg_in, bus.enemy_dmg_in}, 0);
        front_q.delete(); move_q.delete(); dmg_q.delete();
        cur_pf = 9'(FM); cur_ef = 9'd0;
      end else begin
        bit exp_m, exp_d;
        dmg_ev_t d;
        while (front_q.size() > 0 && front_q[0].cyc <= cyc) begin
          cur_pf = front_q[0].pf; cur_ef = front_q[0].ef;
          void'(front_q.pop_front());
        end
        chk("player_front", bus.player_front, cur_pf);
        chk("enemy_front", bus.enemy_front, cur_ef);
        exp_m = (move_q.size() > 0 && move_q[0] == cyc);
        chk("move_scen", bus.move_scen, exp_m);
        if (exp_m) void'(move_q.pop_front());
        exp_d = (dmg_q.size() > 0 && dmg_q[0].cyc == cyc);
        d.pv = '0; d.ev = '0;
        if (exp_d) d = dmg_q.pop_front();
        chk("damage_scen", bus.damage_scen, exp_d);
        chk("player_dmg_in", bus.player_dmg_in, d.pv);
        chk("enemy_dmg_in", bus.enemy_dmg_in, d.ev);
        chk("base_hit", bus.base_hit, (cyc >= halt_cyc));
      end
    end
  end

  initial begin
    int guard;
    en = 1'b1;
    kill_all();
    model_clear();
    drive();
    reset_dut(3);

    // no units alive: bare tick cadence
    repeat (40) one_cycle();

    // fronts from players at 300/250 and enemy at 10
    ppos[0] = 9'd300; palive[0] = 1; ppos[1] = 9'd250; palive[1] = 1;
    epos[0] = 9'd10;  ealive[0] = 1;
    repeat (16) one_cycle();

    // player tie at 120 and saturated player damage sum
    kill_all();
    ppos[0] = 9'd120; pdmg[0] = 8'h20; palive[0] = 1;
    ppos[1] = 9'd120; pdmg[1] = 8'hF0; palive[1] = 1;
    epos[2] = 9'd119; ealive[2] = 1;
    repeat (16) one_cycle();

    // two enemies tied at 50
    kill_all();
    ppos[3] = 9'd200; palive[3] = 1; pdmg[3] = 8'h11;
    epos[1] = 9'd50; edmg[1] = 8'h40; ealive[1] = 1;
    epos[3] = 9'd50; edmg[3] = 8'h40; ealive[3] = 1;
    repeat (16) one_cycle();

    // enable low for 20 cycles from count 5
    guard = 0;
    while (mcount != 5 && guard < 4 * TD) begin one_cycle(); guard++; end
    chk("reach_count5", mcount, 5);
    en = 1'b0;
    repeat (20) one_cycle();
    en = 1'b1;
    repeat (16) one_cycle();

    // randomized traffic with occasional enable drops and mid-sequence resets
    for (int n = 0; n < 600; n++) begin
      if (n % 10 == 0) randomize_units();
      en = ($urandom_range(0, 9) != 0);
      if (cyc == busy_until - 2 && $urandom_range(0, 7) == 0) reset_dut(2);
      else one_cycle();
    end
    en = 1'b1;

    // enemy breach halts the sequencer until reset
    kill_all();
    repeat (10) one_cycle();
    epos[0] = 9'd400; ealive[0] = 1; edmg[0] = 8'h33;
    ppos[0] = 9'd390; palive[0] = 1;
    repeat (30) one_cycle();
    chk("halt_reached", halted, 1);
    kill_all();
    reset_dut(2);
    repeat (20) one_cycle();

    repeat (8) one_cycle();
    @(posedge clk); #3;
    chk("pending_moves", move_q.size(), 0);
    chk("pending_damage", dmg_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
